traffic_light_monitor: RTL and testbench

//  Passive checker on the consuming side of the traffic_light_controller light bus.

---
 rtl/traffic_light_monitor.sv | 197 +++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive protocol checker for the four-lamp light bus.
// Tracks a phase FSM and dwell counter per lamp and raises sticky error flags.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   light_M1/M2/MT/S lamp samples, {R,Y,G} one-hot: 100 RED, 010 YEL, 001 GRN
//   clr_err          one-cycle pulse clearing the sticky flags
//   err_enc          sticky illegal-encoding flag per lamp {S,MT,M2,M1}
//   err_trans        sticky illegal-transition flag per lamp {S,MT,M2,M1}
//   err_dwell        sticky dwell-time violation flag per lamp {S,MT,M2,M1}
//   err_conflict     sticky conflicting-green flag
//   err_any          registered OR of all sticky flags
//   m1_cycles        count of M1 RED->GRN transitions (wraps)
module traffic_light_monitor #(
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned MIN_YELLOW = 2,
    parameter int unsigned MAX_YELLOW = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  light_M1,
    input  logic [2:0]  light_M2,
    input  logic [2:0]  light_MT,
    input  logic [2:0]  light_S,
    input  logic        clr_err,
    output logic [3:0]  err_enc,
    output logic [3:0]  err_trans,
    output logic [3:0]  err_dwell,
    output logic        err_conflict,
    output logic        err_any,
    output logic [15:0] m1_cycles
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RED,
        ST_YEL,
        ST_GRN
    } phase_e;

    localparam logic [2:0] ENC_RED = 3'b100;
    localparam logic [2:0] ENC_YEL = 3'b010;
    localparam logic [2:0] ENC_GRN = 3'b001;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_G   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_Y   = CNT_W'(MAX_YELLOW);

    // Lamp index order matches the flag bit order {S,MT,M2,M1}.
    logic [2:0]       light [4];

    phase_e           state_q [4];
    phase_e           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];

    logic [3:0]       err_enc_q, err_enc_d;
    logic [3:0]       err_trans_q, err_trans_d;
    logic [3:0]       err_dwell_q, err_dwell_d;
    logic             err_conflict_q, err_conflict_d;
    logic             err_any_q, err_any_d;
    logic [15:0]      m1_cycles_q, m1_cycles_d;

    phase_e           sample [4];
    logic [3:0]       legal;
    logic [3:0]       active;
    logic [3:0]       hit_enc;
    logic [3:0]       hit_trans;
    logic [3:0]       hit_dwell;
    logic             hit_conflict;
    logic             m1_rise;

    assign light[0] = light_M1;
    assign light[1] = light_M2;
    assign light[2] = light_MT;
    assign light[3] = light_S;

    // Decode each lamp sample into a phase; anything not one-hot is illegal.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            legal[i]  = 1'b1;
            sample[i] = ST_INIT;
            case (light[i])
                ENC_RED: sample[i] = ST_RED;
                ENC_YEL: sample[i] = ST_YEL;
                ENC_GRN: sample[i] = ST_GRN;
                default: legal[i]  = 1'b0;
            endcase
            // Only a legal, non-red lamp counts as showing a go aspect.
            active[i] = legal[i] && (sample[i] != ST_RED);
        end
    end

    // Per-lamp phase tracking, transition legality and dwell checks.
    always_comb begin
        hit_enc   = '0;
        hit_trans = '0;
        hit_dwell = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!legal[i]) begin
                // Illegal sample: freeze phase and counter.
                hit_enc[i] = 1'b1;
            end else if (state_q[i] == ST_INIT) begin
                state_d[i] = sample[i];
                cnt_d[i]   = CNT_ONE;
            end else if (sample[i] == state_q[i]) begin
                if (cnt_q[i] != CNT_SAT) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
                // Counter passes MAX_Y exactly once per yellow interval.
                if (state_q[i] == ST_YEL && cnt_q[i] == MAX_Y) begin
                    hit_dwell[i] = 1'b1;
                end
            end else begin
                state_d[i] = sample[i];
                cnt_d[i]   = CNT_ONE;
                unique case (1'b1)
                    (state_q[i] == ST_RED && sample[i] == ST_GRN): begin
                    end
                    (state_q[i] == ST_GRN && sample[i] == ST_YEL): begin
                        if (cnt_q[i] < MIN_G) begin
                            hit_dwell[i] = 1'b1;
                        end
                    end
                    (state_q[i] == ST_YEL && sample[i] == ST_RED): begin
                        if (cnt_q[i] < MIN_Y) begin
                            hit_dwell[i] = 1'b1;
                        end
                    end
                    default: hit_trans[i] = 1'b1;
                endcase
            end
        end
    end

    // Side conflicts with any main lamp; turn conflicts with main road 2.
    always_comb begin
        hit_conflict = (active[3] && (|active[2:0]))
                    || (active[2] && active[1]);
    end

    always_comb begin
        m1_rise = legal[0]
               && (state_q[0] == ST_RED)
               && (sample[0] == ST_GRN);
    end

    // Sticky flags: a new violation wins over a simultaneous clear.
    always_comb begin
        err_enc_d      = (err_enc_q & {4{~clr_err}}) | hit_enc;
        err_trans_d    = (err_trans_q & {4{~clr_err}}) | hit_trans;
        err_dwell_d    = (err_dwell_q & {4{~clr_err}}) | hit_dwell;
        err_conflict_d = (err_conflict_q & ~clr_err) | hit_conflict;
        err_any_d      = (|err_enc_q) | (|err_trans_q)
                       | (|err_dwell_q) | err_conflict_q;
        m1_cycles_d    = m1_cycles_q + 16'(m1_rise);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_INIT;
                cnt_q[i]   <= '0;
            end
            err_enc_q      <= '0;
            err_trans_q    <= '0;
            err_dwell_q    <= '0;
            err_conflict_q <= 1'b0;
            err_any_q      <= 1'b0;
            m1_cycles_q    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            err_enc_q      <= err_enc_d;
            err_trans_q    <= err_trans_d;
            err_dwell_q    <= err_dwell_d;
            err_conflict_q <= err_conflict_d;
            err_any_q      <= err_any_d;
            m1_cycles_q    <= m1_cycles_d;
        end
    end

    assign err_enc      = err_enc_q;
    assign err_trans    = err_trans_q;
    assign err_dwell    = err_dwell_q;
    assign err_conflict = err_conflict_q;
    assign err_any      = err_any_q;
    assign m1_cycles    = m1_cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the monitor rules.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam int MIN_GREEN  = 4;
    localparam int MIN_YELLOW = 2;
    localparam int MAX_YELLOW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_err = 1'b0;
    logic [2:0]  l_m1 = R;
    logic [2:0]  l_m2 = R;
    logic [2:0]  l_mt = R;
    logic [2:0]  l_s  = R;
    logic [3:0]  err_enc, err_trans, err_dwell;
    logic        err_conflict, err_any;
    logic [15:0] m1_cycles;

    int checks   = 0;
    int failures = 0;

    // Model state: last legal colour per lamp (-1 none, 0 R, 1 G, 2 Y)
    // and how many consecutive samples it has been shown.
    logic [3:0]  m_enc, m_trans, m_dwell;
    logic        m_conf, m_any;
    logic [15:0] m_m1;
    int          col [4];
    int          run [4];

    traffic_light_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .light_M1     (l_m1),
        .light_M2     (l_m2),
        .light_MT     (l_mt),
        .light_S      (l_s),
        .clr_err      (clr_err),
        .err_enc      (err_enc),
        .err_trans    (err_trans),
        .err_dwell    (err_dwell),
        .err_conflict (err_conflict),
        .err_any      (err_any),
        .m1_cycles    (m1_cycles)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [2:0] lv [4];
        logic [3:0] he, ht, hd;
        logic       hc;
        bit         act [4];
        int         code;
        lv[0] = l_m1; lv[1] = l_m2; lv[2] = l_mt; lv[3] = l_s;
        if (rst) begin
            m_enc = '0; m_trans = '0; m_dwell = '0;
            m_conf = 1'b0; m_any = 1'b0; m_m1 = '0;
            for (int i = 0; i < 4; i++) begin
                col[i] = -1;
                run[i] = 0;
            end
            return;
        end
        he = '0; ht = '0; hd = '0;
        for (int i = 0; i < 4; i++) begin
            case (lv[i])
                R:       code = 0;
                G:       code = 1;
                Y:       code = 2;
                default: code = -1;
            endcase
            act[i] = (code > 0);
            if (code < 0) begin
                he[i] = 1'b1;
            end else if (col[i] < 0) begin
                col[i] = code;
                run[i] = 1;
            end else if (code == col[i]) begin
                if (col[i] == 2 && run[i] == MAX_YELLOW) hd[i] = 1'b1;
                if (run[i] < 255) run[i] = run[i] + 1;
            end else begin
                // Legal cycle order is R -> G -> Y -> R.
                if (code != (col[i] + 1) % 3) ht[i] = 1'b1;
                if (col[i] == 1 && code == 2 && run[i] < MIN_GREEN)
                    hd[i] = 1'b1;
                if (col[i] == 2 && code == 0 && run[i] < MIN_YELLOW)
                    hd[i] = 1'b1;
                if (i == 0 && col[i] == 0 && code == 1) m_m1 = m_m1 + 16'd1;
                col[i] = code;
                run[i] = 1;
            end
        end
        hc = (act[3] && (act[0] || act[1] || act[2])) || (act[2] && act[1]);
        m_any = (|m_enc) | (|m_trans) | (|m_dwell) | m_conf;
        if (clr_err) begin
            m_enc = '0; m_trans = '0; m_dwell = '0; m_conf = 1'b0;
        end
        m_enc   = m_enc | he;
        m_trans = m_trans | ht;
        m_dwell = m_dwell | hd;
        m_conf  = m_conf | hc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_all(input logic [2:0] a, b, c, d);
        l_m1 = a; l_m2 = b; l_mt = c; l_s = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_err = 1'b0;
        set_all(R, R, R, R);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({err_enc, err_trans, err_dwell, err_conflict, err_any} !== 14'd0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0",
                     {err_enc, err_trans, err_dwell, err_conflict, err_any});
        end
        checks++;
        if (m1_cycles !== 16'd0) begin
            failures++;
            $display("FAIL reset_m1 got=%0d exp=0", m1_cycles);
        end
    endtask

    task automatic test_legal_sequence();
        do_reset();
        l_m1 = G; repeat (5) tick();
        l_m1 = Y; repeat (3) tick();
        l_m1 = R; repeat (6) tick();
        checks++;
        if (m1_cycles !== 16'd0) begin
            failures++;
            $display("FAIL legal_m1_pre got=%0d exp=0", m1_cycles);
        end
        l_m1 = G; tick();
        tick();
        checks++;
        if ({err_enc, err_trans, err_dwell, err_conflict, err_any} !== 14'd0) begin
            failures++;
            $display("FAIL legal_flags got=%b exp=0",
                     {err_enc, err_trans, err_dwell, err_conflict, err_any});
        end
        checks++;
        if (m1_cycles !== 16'd1) begin
            failures++;
            $display("FAIL legal_m1 got=%0d exp=1", m1_cycles);
        end
    endtask

    task automatic test_bad_transition();
        do_reset();
        l_m1 = G; repeat (5) tick();
        l_m1 = R; tick();
        checks++;
        if (err_trans !== 4'b0001) begin
            failures++;
            $display("FAIL trans_flag got=%b exp=0001", err_trans);
        end
        checks++;
        if (err_any !== 1'b0) begin
            failures++;
            $display("FAIL trans_any_early got=%b exp=0", err_any);
        end
        tick();
        checks++;
        if (err_any !== 1'b1) begin
            failures++;
            $display("FAIL trans_any got=%b exp=1", err_any);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        set_all(G, R, R, G); tick();
        checks++;
        if (err_conflict !== 1'b1 || err_trans !== 4'b0000) begin
            failures++;
            $display("FAIL conf_s_m1 got=%b/%b exp=1/0000", err_conflict, err_trans);
        end
        do_reset();
        set_all(R, G, Y, R); tick();
        checks++;
        if (err_conflict !== 1'b1) begin
            failures++;
            $display("FAIL conf_mt_m2 got=%b exp=1", err_conflict);
        end
        do_reset();
        set_all(G, G, R, R); tick();
        checks++;
        if (err_conflict !== 1'b0) begin
            failures++;
            $display("FAIL conf_m1_m2 got=%b exp=0", err_conflict);
        end
        do_reset();
        set_all(G, R, R, 3'b011); tick();
        checks++;
        if (err_conflict !== 1'b0 || err_enc !== 4'b1000) begin
            failures++;
            $display("FAIL conf_illegal got=%b/%b exp=0/1000", err_conflict, err_enc);
        end
    endtask

    task automatic test_dwell();
        do_reset();
        l_m2 = G; repeat (4) tick();
        l_m2 = Y; tick();
        l_m2 = R; tick();
        checks++;
        if (err_dwell !== 4'b0010) begin
            failures++;
            $display("FAIL dwell_short_yel got=%b exp=0010", err_dwell);
        end
        do_reset();
        l_m2 = G; repeat (4) tick();
        l_m2 = Y; repeat (8) tick();
        checks++;
        if (err_dwell !== 4'b0000) begin
            failures++;
            $display("FAIL dwell_yel8 got=%b exp=0000", err_dwell);
        end
        tick();
        checks++;
        if (err_dwell !== 4'b0010) begin
            failures++;
            $display("FAIL dwell_yel9 got=%b exp=0010", err_dwell);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        tick();
        checks++;
        if (err_dwell !== 4'b0000) begin
            failures++;
            $display("FAIL dwell_once got=%b exp=0000", err_dwell);
        end
        do_reset();
        l_m1 = G; repeat (300) tick();
        l_m1 = Y; tick();
        checks++;
        if (err_dwell !== 4'b0000) begin
            failures++;
            $display("FAIL dwell_sat got=%b exp=0000", err_dwell);
        end
    endtask

    task automatic test_encoding_clear();
        do_reset();
        tick();
        l_mt = 3'b110; tick();
        checks++;
        if (err_enc !== 4'b0100) begin
            failures++;
            $display("FAIL enc_110 got=%b exp=0100", err_enc);
        end
        l_mt = 3'b000; tick();
        l_mt = R; tick();
        checks++;
        if (err_trans !== 4'b0000 || err_enc !== 4'b0100) begin
            failures++;
            $display("FAIL enc_hold got=%b/%b exp=0000/0100", err_trans, err_enc);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++;
        if (err_enc !== 4'b0000 || err_any !== 1'b1) begin
            failures++;
            $display("FAIL clr got=%b/%b exp=0000/1", err_enc, err_any);
        end
        tick();
        checks++;
        if (err_any !== 1'b0) begin
            failures++;
            $display("FAIL clr_any got=%b exp=0", err_any);
        end
        clr_err = 1'b1; l_mt = 3'b111; tick();
        clr_err = 1'b0; l_mt = R;
        checks++;
        if (err_enc !== 4'b0100) begin
            failures++;
            $display("FAIL clr_vs_err got=%b exp=0100", err_enc);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        l_m1 = G; repeat (5) tick();
        l_mt = 3'b111; tick();
        l_mt = R;
        l_m1 = Y; repeat (2) tick();
        checks++;
        if (err_enc !== 4'b0100) begin
            failures++;
            $display("FAIL mid_pre got=%b exp=0100", err_enc);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({err_enc, err_trans, err_dwell, err_conflict, err_any, m1_cycles} !== 30'd0) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=0",
                     {err_enc, err_trans, err_dwell, err_conflict, err_any, m1_cycles});
        end
        l_m1 = R; tick();
        checks++;
        if (err_trans !== 4'b0000) begin
            failures++;
            $display("FAIL mid_init got=%b exp=0000", err_trans);
        end
        l_m1 = G; tick();
        checks++;
        if (m1_cycles !== 16'd1) begin
            failures++;
            $display("FAIL mid_m1 got=%0d exp=1", m1_cycles);
        end
    endtask

    task automatic test_random();
        logic [2:0] cur [4];
        int r;
        do_reset();
        for (int i = 0; i < 4; i++) cur[i] = R;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                r = int'($urandom_range(0, 99));
                if (r < 70) begin
                end else if (r < 90) begin
                    case (cur[i])
                        R:       cur[i] = G;
                        G:       cur[i] = Y;
                        default: cur[i] = R;
                    endcase
                end else if (r < 96) begin
                    case ($urandom_range(0, 2))
                        0:       cur[i] = R;
                        1:       cur[i] = Y;
                        default: cur[i] = G;
                    endcase
                end else begin
                    cur[i] = 3'($urandom);
                end
            end
            set_all(cur[0], cur[1], cur[2], cur[3]);
            clr_err = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if ({err_enc, err_trans, err_dwell} !== {m_enc, m_trans, m_dwell}) begin
                failures++;
                $display("FAIL rnd_flags n=%0d got=%b exp=%b", n,
                         {err_enc, err_trans, err_dwell}, {m_enc, m_trans, m_dwell});
            end
            checks++;
            if ({err_conflict, err_any} !== {m_conf, m_any}) begin
                failures++;
                $display("FAIL rnd_conf_any n=%0d got=%b exp=%b", n,
                         {err_conflict, err_any}, {m_conf, m_any});
            end
            checks++;
            if (m1_cycles !== m_m1) begin
                failures++;
                $display("FAIL rnd_m1 n=%0d got=%0d exp=%0d", n, m1_cycles, m_m1);
            end
        end
        rst = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_legal_sequence();
        test_bad_transition();
        test_conflict();
        test_dwell();
        test_encoding_clear();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
